// File: rtl/spi_ram_scheduler_pkg.sv
// Shared types for the SPI wrapper: slave FSM states, SPI command opcodes,
// the RAM arbiter states and the requester identifiers.
package spi_ram_scheduler_pkg;

  localparam int DATA_W = 8;
  localparam int CMD_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACC,
    ARB_RD
  } arb_state_e;

  typedef enum logic {
    REQ_HOST,
    REQ_SPI
  } requester_e;

  // Opcodes with bit 0 set touch the RAM; the others only load an address.
  function automatic logic is_mem_cmd(input spi_cmd_e cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/spi_ram_scheduler_if.sv
// Bundle of the SPI command/response, host port and RAM port signals.
// "slave" is the scheduler's view, "master" is the surrounding wrapper's view.
interface spi_ram_scheduler_if #(
  parameter int ADDR_SIZE = 8
);
  import spi_ram_scheduler_pkg::*;

  logic                  rx_valid;
  logic [CMD_W-1:0]      rx_data;
  logic                  tx_valid;
  logic [DATA_W-1:0]     tx_data;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_SIZE-1:0]  host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_W-1:0]     host_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  err_ovr;

  modport slave (
    input  rx_valid, rx_data,
    output tx_valid, tx_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err_ovr
  );

  modport master (
    output rx_valid, rx_data,
    input  tx_valid, tx_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err_ovr
  );

endinterface

// File: rtl/spi_ram_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 = host, bit 1 = SPI; on a tie the
// requester not granted last wins, and priority only moves when adv is high.
module rr_arbiter2
  import spi_ram_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  requester_e last_gnt_q, last_gnt_d;

  always_comb begin
    gnt        = req;
    last_gnt_d = last_gnt_q;
    if (req[0] && req[1]) begin
      gnt = (last_gnt_q == REQ_HOST) ? 2'b10 : 2'b01;
    end
    if (adv && (|gnt)) begin
      last_gnt_d = gnt[1] ? REQ_SPI : REQ_HOST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= REQ_HOST;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/spi_ram_scheduler.sv
// Decodes SPI command words into address latches and queued RAM accesses,
// and shares the single-port RAM between that queue and the local host port.
module spi_ram_scheduler
  import spi_ram_scheduler_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ram_scheduler_if.slave bus
);

  arb_state_e             state_q, state_d;

  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;

  logic                   slot_valid_q, slot_valid_d;
  logic                   slot_we_q, slot_we_d;
  logic [ADDR_SIZE-1:0]   slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]      slot_data_q, slot_data_d;

  logic                   acc_we_q, acc_we_d;
  requester_e             acc_src_q, acc_src_d;
  logic [ADDR_SIZE-1:0]   acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]      acc_wdata_q, acc_wdata_d;

  logic                   tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]      tx_data_q, tx_data_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;
  logic                   err_ovr_q, err_ovr_d;

  spi_cmd_e               cmd;
  logic [DATA_W-1:0]      payload;
  logic [1:0]             arb_req;
  logic [1:0]             arb_gnt;
  logic                   arb_adv;
  logic                   spi_gnt;
  logic                   host_gnt_w;

  assign cmd     = spi_cmd_e'(bus.rx_data[9:8]);
  assign payload = bus.rx_data[7:0];
  assign arb_req = {slot_valid_q, bus.host_req};
  assign arb_adv = (state_q == ARB_IDLE);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  assign spi_gnt    = arb_adv && arb_gnt[1];
  assign host_gnt_w = arb_adv && arb_gnt[0];

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    slot_valid_d  = slot_valid_q;
    slot_we_d     = slot_we_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    acc_we_d      = acc_we_q;
    acc_src_d     = acc_src_q;
    acc_addr_d    = acc_addr_q;
    acc_wdata_d   = acc_wdata_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    err_ovr_d     = err_ovr_q;

    if (spi_gnt) begin
      slot_valid_d = 1'b0;
    end

    if (bus.rx_valid) begin
      tx_valid_d = 1'b0;
      if (cmd == WR_ADDR) wr_addr_d = payload;
      if (cmd == RD_ADDR) rd_addr_d = payload;
      // The slot frees up in its own grant cycle, so a command arriving
      // then takes the slot instead of being counted as an overrun.
      if (is_mem_cmd(cmd)) begin
        if (!slot_valid_q || spi_gnt) begin
          slot_valid_d = 1'b1;
          slot_we_d    = (cmd == WR_DATA);
          slot_addr_d  = (cmd == WR_DATA) ? wr_addr_q : rd_addr_q;
          slot_data_d  = payload;
        end else begin
          err_ovr_d = 1'b1;
        end
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (spi_gnt) begin
          state_d     = ARB_ACC;
          acc_src_d   = REQ_SPI;
          acc_we_d    = slot_we_q;
          acc_addr_d  = slot_addr_q;
          acc_wdata_d = slot_data_q;
        end else if (host_gnt_w) begin
          state_d     = ARB_ACC;
          acc_src_d   = REQ_HOST;
          acc_we_d    = bus.host_we;
          acc_addr_d  = bus.host_addr;
          acc_wdata_d = bus.host_wdata;
        end
      end
      ARB_ACC: begin
        state_d = acc_we_q ? ARB_IDLE : ARB_RD;
      end
      ARB_RD: begin
        state_d = ARB_IDLE;
        if (acc_src_q == REQ_SPI) begin
          tx_valid_d = 1'b1;
          tx_data_d  = bus.mem_rdata;
        end else begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = bus.mem_rdata;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      slot_valid_q  <= 1'b0;
      slot_we_q     <= 1'b0;
      slot_addr_q   <= '0;
      slot_data_q   <= '0;
      acc_we_q      <= 1'b0;
      acc_src_q     <= REQ_HOST;
      acc_addr_q    <= '0;
      acc_wdata_q   <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      err_ovr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      slot_valid_q  <= slot_valid_d;
      slot_we_q     <= slot_we_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      acc_we_q      <= acc_we_d;
      acc_src_q     <= acc_src_d;
      acc_addr_q    <= acc_addr_d;
      acc_wdata_q   <= acc_wdata_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      err_ovr_q     <= err_ovr_d;
    end
  end

  assign bus.mem_en      = (state_q == ARB_ACC);
  assign bus.mem_we      = (state_q == ARB_ACC) && acc_we_q;
  assign bus.mem_addr    = acc_addr_q;
  assign bus.mem_wdata   = acc_wdata_q;
  assign bus.host_gnt    = host_gnt_w;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_spi_ram_scheduler.sv
// Cycle-by-cycle vector bench for spi_ram_scheduler with a behavioural RAM
// attached to the memory port.
module tb_spi_ram_scheduler;

  logic clk;
  logic rst_n;

  spi_ram_scheduler_if bus ();

  spi_ram_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, data one cycle after mem_en.
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    logic       rxv;
    logic [9:0] rxd;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;
    logic       e_gnt;
    logic       e_en;
    logic       e_we;
    logic [7:0] e_addr;
    logic [7:0] e_wd;
    logic       e_txv;
    logic [7:0] e_txd;
    logic       e_hrv;
    logic [7:0] e_hrd;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(
    input logic rxv, input logic [9:0] rxd,
    input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [7:0] hwd,
    input logic gnt, input logic en, input logic we, input logic [7:0] addr, input logic [7:0] wd,
    input logic txv, input logic [7:0] txd, input logic hrv, input logic [7:0] hrd,
    input logic err);
    vec_t r;
    r.rxv = rxv; r.rxd = rxd; r.hreq = hreq; r.hwe = hwe; r.haddr = haddr; r.hwd = hwd;
    r.e_gnt = gnt; r.e_en = en; r.e_we = we; r.e_addr = addr; r.e_wd = wd;
    r.e_txv = txv; r.e_txd = txd; r.e_hrv = hrv; r.e_hrd = hrd; r.e_err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive_idle();
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tname);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.rx_valid   = tbl[i].rxv;
      bus.rx_data    = tbl[i].rxd;
      bus.host_req   = tbl[i].hreq;
      bus.host_we    = tbl[i].hwe;
      bus.host_addr  = tbl[i].haddr;
      bus.host_wdata = tbl[i].hwd;
      #2;
      chk($sformatf("%s c%0d host_gnt", tname, i), {7'd0, bus.host_gnt}, {7'd0, tbl[i].e_gnt});
      chk($sformatf("%s c%0d mem_en", tname, i), {7'd0, bus.mem_en}, {7'd0, tbl[i].e_en});
      if (tbl[i].e_en) begin
        chk($sformatf("%s c%0d mem_we", tname, i), {7'd0, bus.mem_we}, {7'd0, tbl[i].e_we});
        chk($sformatf("%s c%0d mem_addr", tname, i), bus.mem_addr, tbl[i].e_addr);
        if (tbl[i].e_we)
          chk($sformatf("%s c%0d mem_wdata", tname, i), bus.mem_wdata, tbl[i].e_wd);
      end
      chk($sformatf("%s c%0d tx_valid", tname, i), {7'd0, bus.tx_valid}, {7'd0, tbl[i].e_txv});
      chk($sformatf("%s c%0d tx_data", tname, i), bus.tx_data, tbl[i].e_txd);
      chk($sformatf("%s c%0d host_rvalid", tname, i), {7'd0, bus.host_rvalid}, {7'd0, tbl[i].e_hrv});
      chk($sformatf("%s c%0d host_rdata", tname, i), bus.host_rdata, tbl[i].e_hrd);
      chk($sformatf("%s c%0d err_ovr", tname, i), {7'd0, bus.err_ovr}, {7'd0, tbl[i].e_err});
      $display("%s c%0d: rx=%0b/%03h host=%0b gnt=%0b en=%0b we=%0b addr=%02h wd=%02h tx=%0b/%02h hr=%0b/%02h err=%0b",
               tname, i, tbl[i].rxv, tbl[i].rxd, tbl[i].hreq, bus.host_gnt, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata, bus.tx_valid, bus.tx_data, bus.host_rvalid,
               bus.host_rdata, bus.err_ovr);
    end
    tbl.delete();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 8'h00;
    ram[8'h10] = 8'h5C;
    ram[8'h20] = 8'hC3;
    ram[8'h07] = 8'h7E;
    bus.mem_rdata = 8'h00;
    do_reset();

    // SPI write 0xA5 to 0x05, read it back, hold tx until next rx, then queue a read of 0x07.
    tbl.push_back(v(1, 10'h005, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h1A5, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h205, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h300, 0,0,8'h00,8'h00, 0,1,1,8'h05,8'hA5, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,0,8'h05,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h005, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h207, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h300, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'hA5, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,0,8'h07,8'h00, 0,8'hA5, 0,8'h00, 0));
    run_table("wr_rd");

    // Reset while the FSM sits in ARB_RD for the read of 0x07.
    @(negedge clk);
    drive_idle();
    #2;
    chk("rst_mid pre mem_en", {7'd0, bus.mem_en}, 8'd0);
    chk("rst_mid pre mem_addr", bus.mem_addr, 8'h07);
    rst_n = 1'b0;
    #1;
    chk("rst_mid tx_data", bus.tx_data, 8'h00);
    chk("rst_mid tx_valid", {7'd0, bus.tx_valid}, 8'd0);
    chk("rst_mid mem_addr", bus.mem_addr, 8'h00);
    chk("rst_mid mem_en", {7'd0, bus.mem_en}, 8'd0);
    chk("rst_mid err_ovr", {7'd0, bus.err_ovr}, 8'd0);
    chk("rst_mid host_rdata", bus.host_rdata, 8'h00);
    $display("rst_mid: reset asserted in ARB_RD, tx=%0b/%02h addr=%02h", bus.tx_valid, bus.tx_data, bus.mem_addr);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("rst_post c%0d tx_valid", i), {7'd0, bus.tx_valid}, 8'd0);
      chk($sformatf("rst_post c%0d host_rvalid", i), {7'd0, bus.host_rvalid}, 8'd0);
      chk($sformatf("rst_post c%0d mem_en", i), {7'd0, bus.mem_en}, 8'd0);
    end

    // Tie: SPI wins first, host then wins the repeated tie.
    do_reset();
    tbl.push_back(v(1, 10'h177, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h188, 1,0,8'h10,8'h00, 0,1,1,8'h00,8'h77, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 1,0,8'h10,8'h00, 1,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,0,8'h10,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 1,8'h5C, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,1,8'h00,8'h88, 0,8'h00, 0,8'h5C, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h5C, 0));
    run_table("tie");

    // Overrun: second WR_DATA while the first waits behind a host read.
    do_reset();
    tbl.push_back(v(1, 10'h040, 1,0,8'h20,8'h00, 1,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h111, 0,0,8'h00,8'h00, 0,1,0,8'h20,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h122, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 1,8'hC3, 1));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,1,8'h40,8'h11, 0,8'h00, 0,8'hC3, 1));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'hC3, 1));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'hC3, 1));
    run_table("ovr");

    // Address relatch after queueing, then a WR_DATA accepted in the grant cycle.
    do_reset();
    tbl.push_back(v(1, 10'h001, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h133, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h002, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,1,8'h01,8'h33, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h144, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(1, 10'h155, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,1,8'h02,8'h44, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,1,1,8'h02,8'h55, 0,8'h00, 0,8'h00, 0));
    tbl.push_back(v(0, 10'h000, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00, 0));
    run_table("relatch");

    // Contents written by the SPI commands must have landed at the captured addresses.
    chk("ram[05]", ram[8'h05], 8'hA5);
    chk("ram[40]", ram[8'h40], 8'h11);
    chk("ram[01]", ram[8'h01], 8'h33);
    chk("ram[02]", ram[8'h02], 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_scheduler.md
# spi_ram_scheduler

Sequences and shares the single-port RAM behind the SPI slave. Decodes 10-bit SPI command words (rx_valid/rx_data) into address latches and memory accesses, and round-robin arbitrates those accesses against a local host port. Read data is returned to the SPI slave on tx_valid/tx_data or to the host on host_rvalid/host_rdata. Sits between the SPI slave and the RAM inside the SPI wrapper.

## Interface
- ADDR_SIZE, 8, RAM address width; MEM_DEPTH = 2**ADDR_SIZE, no wrap logic needed.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete SPI command.
- rx_data  in  10  [9:8] opcode, [7:0] payload.
- tx_valid  out  1  SPI read data valid; load strobe for the slave's shifter.
- tx_data  out  8  SPI read data.
- host_req  in  1  host access request; held with its fields until host_gnt.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  8  host write data.
- host_gnt  out  1  one-cycle pulse; host fields are sampled this cycle.
- host_rvalid  out  1  one-cycle pulse with host_rdata.
- host_rdata  out  8  host read data.
- mem_en  out  1  RAM access strobe, one cycle per access.
- mem_we  out  1  RAM write enable, qualified by mem_en.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid the cycle after mem_en with mem_we=0.
- err_ovr  out  1  sticky: an SPI memory command was dropped; cleared only by reset.

## Operation
- Opcode decode on rx_valid:
  - 00 WR_ADDR: wr_addr <= payload. No RAM access.
  - 01 WR_DATA: queue a write of payload to the current wr_addr.
  - 10 RD_ADDR: rd_addr <= payload. No RAM access.
  - 11 RD_DATA: queue a read of the current rd_addr. The payload is ignored.
- Address opcodes take effect immediately, even while an SPI access is pending.
- The SPI pending slot is one entry deep. It stores the opcode, the address captured at acceptance time, and the data. Later address updates do not alter a queued access.
- Memory opcode arriving while the slot is full and not being granted that cycle: dropped, err_ovr <= 1.
- Arbiter state machine (arb_state_e):
  - IDLE: pick a requester. If none, stay.
  - ACC: drive mem_en for one cycle. Then write -> IDLE, read -> RD.
  - RD: capture mem_rdata, return to IDLE.
- Round-robin between SPI and host. If both request, the one not granted last wins. last_gnt resets to HOST, so SPI wins the first tie. A lone requester is always granted.
- SPI read result: tx_data <= mem_rdata, tx_valid <= 1. Both hold until the next accepted rx_valid of any opcode, which clears tx_valid.
- Host read result: host_rdata <= mem_rdata, host_rvalid pulses once.

## Timing
- Reset values: every output and internal register is 0, including tx_data, host_rdata, mem_addr, wr_addr and rd_addr. State = IDLE, last_gnt = HOST.
- rx_valid in cycle R: the pending slot is visible in R+1. The earliest grant decision is in R+1.
- Grant decision in cycle N (IDLE): host_gnt pulses in N when the host wins. mem_en/mem_we/mem_addr/mem_wdata are driven in N+1.
- Write: FSM is back in IDLE at N+2. A new grant is possible in N+2.
- Read: mem_rdata valid in N+2. tx_valid rises, or host_rvalid pulses, in N+3. The FSM is in IDLE at N+3.
- Slot handling:
  - The slot clears in its grant cycle.
  - An rx_valid in that same cycle is accepted into the slot, with no err_ovr.
- Reset mid-access: all state clears immediately. An in-flight read yields no response. A write may or may not have reached the RAM.

## Structure
- Shared package (alongside the existing SPI state_e):
  - spi_cmd_e {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11}
  - arb_state_e {ARB_IDLE, ARB_ACC, ARB_RD}
  - requester enum {REQ_HOST, REQ_SPI}
- One sub-module, rr_arbiter2. It takes 2 requests and an advance strobe, returns a one-hot grant, and holds the last_gnt priority register.

## Test plan
- SPI write then read back:
  - Stimulus: rx 0x0_05, 0x1_A5, 0x2_05, 0x3_00.
  - Required: mem write to addr 0x05 with data 0xA5. Then tx_valid=1 with tx_data=0xA5 three cycles after grant, held until the next rx_valid.
- Host/SPI tie: host_req (read 0x10) and the SPI WR_DATA slot become valid in the same cycle after reset. Required: SPI is granted first, host second. On a repeated tie the host wins.
- Overrun:
  - Stimulus: SPI WR_DATA pending while a host read holds the RAM, then a second WR_DATA.
  - Required: the second write is dropped, err_ovr=1 and stays set. The first write completes at its captured address.
- Address relatch: queue WR_DATA 0x33 at wr_addr 0x01, then WR_ADDR 0x02 before grant. Required: the RAM write goes to 0x01.
- Grant-cycle accept: rx_valid with WR_DATA in the exact cycle the slot is granted. Required: the new command is queued and err_ovr stays 0.
- Reset mid-read: assert rst_n low during ARB_RD. Required: no tx_valid or host_rvalid, and all outputs are 0 immediately.
